// File: rtl/mips_inst_encoder_if.sv
// Symbolic-instruction stream in, IM write port and session status out.
interface mips_inst_encoder_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [5:0]        mnem;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   word_cnt;
  logic              err_illegal;
  logic              err_overflow;

  modport master (
    output start, base_addr, in_valid, in_last, mnem, rs, rt, rd, shamt, imm, target,
    input  in_ready, im_we, im_addr, im_wdata, busy, done, word_cnt, err_illegal, err_overflow
  );

  modport slave (
    input  start, base_addr, in_valid, in_last, mnem, rs, rt, rd, shamt, imm, target,
    output in_ready, im_we, im_addr, im_wdata, busy, done, word_cnt, err_illegal, err_overflow
  );
endinterface

// File: rtl/mips_inst_encoder.sv
// Encodes symbolic MIPS-I instructions and writes them to consecutive IM addresses.
// Define ENCODER_BRANCH_REL_EN to treat branch imm as an absolute target address.
module mips_inst_encoder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 1024
) (
  input logic               clk,
  input logic               rst,
  mips_inst_encoder_if.slave bus
);
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ill_q, ill_d;
  logic              ovf_q, ovf_d;

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic [15:0]       br_imm;
  logic              br_ok;
  logic              accept;

  function automatic logic [31:0] r_word(input logic [4:0] s, input logic [4:0] t,
                                         input logic [4:0] d, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {6'b000000, s, t, d, sh, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] s,
                                         input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

`ifdef ENCODER_BRANCH_REL_EN
  logic signed [31:0] br_diff;

  // Branch offset is relative to the slot after the one being written.
  always_comb begin
    br_diff = $signed({16'd0, bus.imm}) - $signed(32'(ptr_q)) - 32'sd1;
    br_imm  = br_diff[15:0];
    br_ok   = (br_diff <= 32'sd32767) && (br_diff >= -32'sd32768);
  end
`else
  always_comb begin
    br_imm = bus.imm;
    br_ok  = 1'b1;
  end
`endif

  // Mnemonic to instruction word, with forced-zero fields.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (bus.mnem)
      6'd0:  enc_word = r_word(bus.rs, bus.rt, bus.rd, 5'd0, 6'h20);
      6'd1:  enc_word = r_word(bus.rs, bus.rt, bus.rd, 5'd0, 6'h21);
      6'd2:  enc_word = r_word(bus.rs, bus.rt, bus.rd, 5'd0, 6'h22);
      6'd3:  enc_word = r_word(bus.rs, bus.rt, bus.rd, 5'd0, 6'h23);
      6'd4:  enc_word = r_word(bus.rs, bus.rt, bus.rd, 5'd0, 6'h24);
      6'd5:  enc_word = r_word(bus.rs, bus.rt, bus.rd, 5'd0, 6'h25);
      6'd6:  enc_word = r_word(bus.rs, bus.rt, bus.rd, 5'd0, 6'h26);
      6'd7:  enc_word = r_word(bus.rs, bus.rt, bus.rd, 5'd0, 6'h27);
      6'd8:  enc_word = r_word(bus.rs, bus.rt, bus.rd, 5'd0, 6'h2a);
      6'd9:  enc_word = r_word(bus.rs, bus.rt, bus.rd, 5'd0, 6'h2b);
      6'd10: enc_word = r_word(5'd0, bus.rt, bus.rd, bus.shamt, 6'h00);
      6'd11: enc_word = r_word(5'd0, bus.rt, bus.rd, bus.shamt, 6'h02);
      6'd12: enc_word = r_word(5'd0, bus.rt, bus.rd, bus.shamt, 6'h03);
      6'd13: enc_word = r_word(bus.rs, bus.rt, bus.rd, 5'd0, 6'h04);
      6'd14: enc_word = r_word(bus.rs, bus.rt, bus.rd, 5'd0, 6'h06);
      6'd15: enc_word = r_word(bus.rs, bus.rt, bus.rd, 5'd0, 6'h07);
      6'd16: enc_word = r_word(bus.rs, 5'd0, 5'd0, 5'd0, 6'h08);
      6'd17: enc_word = r_word(bus.rs, 5'd0, bus.rd, 5'd0, 6'h09);
      6'd18: enc_word = i_word(6'h08, bus.rs, bus.rt, bus.imm);
      6'd19: enc_word = i_word(6'h09, bus.rs, bus.rt, bus.imm);
      6'd20: enc_word = i_word(6'h0a, bus.rs, bus.rt, bus.imm);
      6'd21: enc_word = i_word(6'h0b, bus.rs, bus.rt, bus.imm);
      6'd22: enc_word = i_word(6'h0c, bus.rs, bus.rt, bus.imm);
      6'd23: enc_word = i_word(6'h0d, bus.rs, bus.rt, bus.imm);
      6'd24: enc_word = i_word(6'h0e, bus.rs, bus.rt, bus.imm);
      6'd25: enc_word = i_word(6'h0f, 5'd0, bus.rt, bus.imm);
      6'd26: enc_word = i_word(6'h23, bus.rs, bus.rt, bus.imm);
      6'd27: enc_word = i_word(6'h2b, bus.rs, bus.rt, bus.imm);
      6'd28: enc_word = i_word(6'h20, bus.rs, bus.rt, bus.imm);
      6'd29: enc_word = i_word(6'h24, bus.rs, bus.rt, bus.imm);
      6'd30: enc_word = i_word(6'h28, bus.rs, bus.rt, bus.imm);
      6'd31: enc_word = i_word(6'h04, bus.rs, bus.rt, br_imm);
      6'd32: enc_word = i_word(6'h05, bus.rs, bus.rt, br_imm);
      6'd33: enc_word = i_word(6'h01, bus.rs, 5'd1, br_imm);
      6'd34: enc_word = i_word(6'h01, bus.rs, 5'd0, br_imm);
      6'd35: enc_word = i_word(6'h07, bus.rs, 5'd0, br_imm);
      6'd36: enc_word = i_word(6'h06, bus.rs, 5'd0, br_imm);
      6'd37: enc_word = {6'h02, bus.target};
      6'd38: enc_word = {6'h03, bus.target};
      default: enc_legal = 1'b0;
    endcase
    if (bus.mnem >= 6'd31 && bus.mnem <= 6'd36) enc_legal = br_ok;
  end

  assign accept = ready_q & bus.in_valid;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    ill_d   = ill_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          ptr_d   = bus.base_addr;
          cnt_d   = '0;
          ill_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (enc_legal) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = enc_word;
            ptr_d   = ptr_q + ADDR_W'(1);
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            ill_d = 1'b1;
          end
          if (bus.in_last) begin
            state_d = S_DONE;
          end else if (enc_legal && cnt_d == MAX_CNT) begin
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_LOAD) && (cnt_d < MAX_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready     = ready_q;
  assign bus.im_we        = we_q;
  assign bus.im_addr      = addr_q;
  assign bus.im_wdata     = wdata_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.word_cnt     = cnt_q;
  assign bus.err_illegal  = ill_q;
  assign bus.err_overflow = ovf_q;
endmodule

// File: tb/tb_mips_inst_encoder.sv
// Bench for mips_inst_encoder: directed vector table, corner sequences and
// randomized sessions checked every cycle against a per-beat reference model.
module tb_mips_inst_encoder;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned MAX_WORDS = 4;
  localparam int unsigned AMOD      = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_inst_encoder_if #(.ADDR_W(ADDR_W)) bus();
  mips_inst_encoder #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int unsigned mn, rs, rt, rd, sh, imm, tgt;
    logic [31:0] exp;
  } vec_t;

  int unsigned funct_tab [18] = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'h26, 32'h27,
                                  32'h2a, 32'h2b, 32'h00, 32'h02, 32'h03, 32'h04, 32'h06, 32'h07,
                                  32'h08, 32'h09};
  int unsigned op_tab [21] = '{32'h08, 32'h09, 32'h0a, 32'h0b, 32'h0c, 32'h0d, 32'h0e, 32'h0f,
                               32'h23, 32'h2b, 32'h20, 32'h24, 32'h28,
                               32'h04, 32'h05, 32'h01, 32'h01, 32'h07, 32'h06, 32'h02, 32'h03};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_load = 1'b0;
  int          m_age  = -1;
  int unsigned m_ptr  = 0;
  int unsigned m_cnt  = 0;
  bit          m_ill  = 1'b0;
  bit          m_ovf  = 1'b0;

  int          n_writes = 0;
  int          n_done   = 0;
  logic [31:0]       wr_data_q [$];
  logic [ADDR_W-1:0] wr_addr_q [$];

  // Beat list for the current session
  int unsigned b_mn [8], b_rs [8], b_rt [8], b_rd [8], b_sh [8], b_imm [8], b_tgt [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_encode(input int unsigned mn, input int unsigned rs, input int unsigned rt,
                                       input int unsigned rd, input int unsigned sh, input int unsigned imm,
                                       input int unsigned tgt, input int unsigned ptr,
                                       output bit legal, output logic [31:0] word);
    int unsigned s, t, d, h, im, op;
    s = rs; t = rt; d = rd; h = sh; im = imm;
    legal = 1'b1;
    word  = '0;
    if (mn <= 17) begin
      if (mn >= 10 && mn <= 12) s = 0; else h = 0;
      if (mn >= 16) t = 0;
      if (mn == 16) d = 0;
      word = s * 32'd2097152 + t * 32'd65536 + d * 32'd2048 + h * 32'd64 + funct_tab[mn];
    end else if (mn <= 36) begin
      op = op_tab[mn - 18];
      if (mn == 25) s = 0;
      if (mn == 33) t = 1;
      if (mn >= 34) t = 0;
`ifdef ENCODER_BRANCH_REL_EN
      if (mn >= 31) begin
        int off;
        off = int'(imm) - int'(ptr) - 1;
        if (off > 32767 || off < -32768) legal = 1'b0;
        im = 32'(off) & 32'hffff;
      end
`endif
      word = op * 32'd67108864 + s * 32'd2097152 + t * 32'd65536 + im;
    end else if (mn <= 38) begin
      word = (mn == 37 ? 32'd2 : 32'd3) * 32'd67108864 + tgt;
    end else begin
      legal = 1'b0;
    end
    if (ptr > AMOD) legal = 1'b0;
  endfunction

  task automatic set_beat(input int unsigned mn, input int unsigned rs, input int unsigned rt,
                          input int unsigned rd, input int unsigned sh, input int unsigned imm,
                          input int unsigned tgt, input bit last, input bit valid);
    bus.mnem = 6'(mn); bus.rs = 5'(rs); bus.rt = 5'(rt); bus.rd = 5'(rd); bus.shamt = 5'(sh);
    bus.imm = 16'(imm); bus.target = 26'(tgt); bus.in_last = last; bus.in_valid = valid;
  endtask

  // One clock: predict from pre-edge inputs, then check every output after the edge.
  task automatic tick(output bit acc);
    bit exp_ready, idle, st, lst, legal, exp_we, exp_done, exp_busy;
    logic [31:0] w;
    int unsigned base, exp_addr;
    exp_ready = m_load && (m_cnt < MAX_WORDS);
    check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
    acc  = bus.in_valid && exp_ready;
    idle = !m_load && (m_age != 0);
    st   = bus.start;
    lst  = bus.in_last;
    base = 32'(bus.base_addr);
    model_encode(32'(bus.mnem), 32'(bus.rs), 32'(bus.rt), 32'(bus.rd), 32'(bus.shamt),
                 32'(bus.imm), 32'(bus.target), m_ptr, legal, w);
    @(posedge clk);
    #1;
    exp_done = 1'b0;
    if (m_age >= 0) begin
      m_age++;
      if (m_age == 1) begin exp_done = 1'b1; m_age = -1; end
    end
    exp_we   = 1'b0;
    exp_addr = 0;
    if (idle && st) begin
      m_ptr = base; m_cnt = 0; m_ill = 1'b0; m_ovf = 1'b0; m_load = 1'b1;
    end else if (m_load && acc) begin
      if (legal) begin
        exp_we = 1'b1; exp_addr = m_ptr;
        m_ptr = (m_ptr + 1) % AMOD;
        m_cnt++;
      end else begin
        m_ill = 1'b1;
      end
      if (lst) begin
        m_load = 1'b0; m_age = 0;
      end else if (legal && m_cnt == MAX_WORDS) begin
        m_ovf = 1'b1; m_load = 1'b0; m_age = 0;
      end
    end
    exp_busy = m_load || (m_age == 0);
    check("im_we", 64'(bus.im_we), 64'(exp_we));
    if (exp_we) begin
      check("im_addr", 64'(bus.im_addr), 64'(exp_addr));
      check("im_wdata", 64'(bus.im_wdata), 64'(w));
    end
    check("done", 64'(bus.done), 64'(exp_done));
    check("busy", 64'(bus.busy), 64'(exp_busy));
    check("word_cnt", 64'(bus.word_cnt), 64'(m_cnt));
    check("err_illegal", 64'(bus.err_illegal), 64'(m_ill));
    check("err_overflow", 64'(bus.err_overflow), 64'(m_ovf));
    if (bus.im_we) begin
      n_writes++;
      wr_data_q.push_back(bus.im_wdata);
      wr_addr_q.push_back(bus.im_addr);
    end
    if (bus.done) n_done++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst in_ready", 64'(bus.in_ready), 64'd0);
    check("rst im_we", 64'(bus.im_we), 64'd0);
    check("rst im_addr", 64'(bus.im_addr), 64'd0);
    check("rst im_wdata", 64'(bus.im_wdata), 64'd0);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst done", 64'(bus.done), 64'd0);
    check("rst word_cnt", 64'(bus.word_cnt), 64'd0);
    check("rst err_illegal", 64'(bus.err_illegal), 64'd0);
    check("rst err_overflow", 64'(bus.err_overflow), 64'd0);
    rst = 1'b0;
    m_load = 1'b0; m_age = -1; m_ptr = 0; m_cnt = 0; m_ill = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic do_start(input int unsigned base);
    bit a;
    bus.base_addr = ADDR_W'(base);
    bus.start = 1'b1;
    tick(a);
    bus.start = 1'b0;
    wr_data_q.delete();
    wr_addr_q.delete();
  endtask

  task automatic drain(input int n, input bit keep_valid);
    bit a;
    bus.in_valid = keep_valid;
    repeat (n) tick(a);
    bus.in_valid = 1'b0;
  endtask

  // Offer nb beats with random valid gaps until consumed or the session ends.
  task automatic run_beats(input int nb, input bit give_last, input int valid_pct, input bit rand_start);
    bit a;
    int k, guard;
    k = 0; guard = 0;
    while (k < nb && m_load && guard < 200) begin
      set_beat(b_mn[k], b_rs[k], b_rt[k], b_rd[k], b_sh[k], b_imm[k], b_tgt[k],
               give_last && (k == nb - 1), $urandom_range(99) < valid_pct);
      bus.start = rand_start && ($urandom_range(7) == 0);
      bus.base_addr = ADDR_W'($urandom_range(AMOD - 1));
      tick(a);
      if (a) k++;
      guard++;
    end
    bus.start = 1'b0;
    if (guard >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL session_timeout: %0d of %0d beats accepted", k, nb);
    end
  endtask

  task automatic load_beat(input int k, input int unsigned mn, input int unsigned rs, input int unsigned rt,
                           input int unsigned rd, input int unsigned sh, input int unsigned imm,
                           input int unsigned tgt);
    b_mn[k] = mn; b_rs[k] = rs; b_rt[k] = rt; b_rd[k] = rd; b_sh[k] = sh; b_imm[k] = imm; b_tgt[k] = tgt;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [$];
    int w0, d0, acc_cnt, guard;
    bit a;
    logic [31:0] tmp;

    bus.start = 1'b0; bus.base_addr = '0;
    set_beat(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    do_reset();

    // addu then ori with in_last
    do_start(32'h010);
    load_beat(0, 1, 1, 2, 3, 0, 0, 0);
    load_beat(1, 23, 0, 4, 0, 0, 32'h00ff, 0);
    d0 = n_done;
    run_beats(2, 1'b1, 100, 1'b0);
    drain(3, 1'b0);
    check("t1 n_writes", 64'(wr_data_q.size()), 64'd2);
    if (wr_data_q.size() == 2) begin
      check("t1 word0", 64'(wr_data_q[0]), 64'h00221821);
      check("t1 addr0", 64'(wr_addr_q[0]), 64'h010);
      check("t1 word1", 64'(wr_data_q[1]), 64'h340400ff);
      check("t1 addr1", 64'(wr_addr_q[1]), 64'h011);
    end
    check("t1 done pulses", 64'(n_done - d0), 64'd1);
    check("t1 word_cnt", 64'(bus.word_cnt), 64'd2);

    // Single-beat vector table
    vecs.push_back('{10, 7, 5, 6, 4, 0, 0, 32'h00053100});
    vecs.push_back('{38, 0, 0, 0, 0, 0, 32'h0100000, 32'h0c100000});
    vecs.push_back('{16, 31, 3, 4, 5, 0, 0, 32'h03e00008});
    vecs.push_back('{25, 9, 2, 0, 0, 32'h1234, 0, 32'h3c021234});
    vecs.push_back('{27, 29, 31, 0, 0, 32'h0004, 0, 32'hafbf0004});
    vecs.push_back('{15, 1, 2, 3, 9, 0, 0, 32'h00221807});
    vecs.push_back('{17, 4, 5, 31, 1, 0, 0, 32'h0080f809});
    vecs.push_back('{7, 10, 11, 12, 3, 0, 0, 32'h014b6027});
    vecs.push_back('{37, 0, 0, 0, 0, 0, 32'h3ffffff, 32'h0bffffff});
`ifndef ENCODER_BRANCH_REL_EN
    vecs.push_back('{33, 8, 0, 0, 0, 32'hfffe, 0, 32'h0501fffe});
    vecs.push_back('{34, 3, 7, 0, 0, 32'h0010, 0, 32'h04600010});
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      do_start(32'h100 + 32'(i));
      load_beat(0, vecs[i].mn, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm, vecs[i].tgt);
      run_beats(1, 1'b1, 100, 1'b0);
      drain(3, 1'b0);
      check($sformatf("vec%0d n_writes", i), 64'(wr_data_q.size()), 64'd1);
      if (wr_data_q.size() == 1) check($sformatf("vec%0d word", i), 64'(wr_data_q[0]), 64'(vecs[i].exp));
    end

    // Illegal mnemonic between two legal beats
    do_start(32'h200);
    load_beat(0, 18, 1, 2, 0, 5, 0, 0);
    load_beat(1, 50, 3, 3, 3, 3, 0, 0);
    load_beat(2, 22, 4, 5, 0, 32'h00f0, 0, 0);
    run_beats(3, 1'b1, 100, 1'b0);
    drain(5, 1'b0);
    check("ill n_writes", 64'(wr_data_q.size()), 64'd2);
    if (wr_addr_q.size() == 2) begin
      check("ill addr0", 64'(wr_addr_q[0]), 64'h200);
      check("ill addr1", 64'(wr_addr_q[1]), 64'h201);
    end
    check("ill sticky", 64'(bus.err_illegal), 64'd1);
    do_start(32'h000);
    check("ill cleared", 64'(bus.err_illegal), 64'd0);
    set_beat(0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    tick(a);
    bus.in_valid = 1'b0;
    drain(3, 1'b0);

    // Overflow: six beats, no in_last, wraps past the top of IM
    do_start(32'h3fe);
    for (int k = 0; k < 6; k++) load_beat(k, 1, k, k + 1, k + 2, 0, 0, 0);
    d0 = n_done;
    run_beats(6, 1'b0, 100, 1'b0);
    drain(4, 1'b1);
    check("ovf n_writes", 64'(wr_data_q.size()), 64'd4);
    if (wr_addr_q.size() == 4) begin
      check("ovf addr2 wrap", 64'(wr_addr_q[2]), 64'h000);
      check("ovf addr3", 64'(wr_addr_q[3]), 64'h001);
    end
    check("ovf flag", 64'(bus.err_overflow), 64'd1);
    check("ovf done pulses", 64'(n_done - d0), 64'd1);

    // Reset after the second accept
    do_start(32'h050);
    acc_cnt = 0; guard = 0;
    while (acc_cnt < 2 && guard < 100) begin
      set_beat(1, 1, 2, 3, 0, 0, 0, 1'b0, $urandom_range(1) == 1);
      tick(a);
      if (a) acc_cnt++;
      guard++;
    end
    if (guard >= 100) begin
      n_checks++; n_fail++;
      $display("FAIL rst_seq_timeout: %0d accepts", acc_cnt);
    end
    do_reset();
    w0 = n_writes; d0 = n_done;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = ($urandom_range(1) == 1);
      tick(a);
    end
    bus.in_valid = 1'b0;
    check("rst no writes", 64'(n_writes - w0), 64'd0);
    check("rst no done", 64'(n_done - d0), 64'd0);

`ifdef ENCODER_BRANCH_REL_EN
    // Branch relative offset and out-of-range target
    do_start(32'h020);
    load_beat(0, 31, 1, 2, 0, 32'h010, 0, 0);
    run_beats(1, 1'b1, 100, 1'b0);
    drain(3, 1'b0);
    check("brel n_writes", 64'(wr_data_q.size()), 64'd1);
    if (wr_data_q.size() == 1) begin
      tmp = wr_data_q[0];
      check("brel offset", 64'(tmp[15:0]), 64'hffef);
    end
    do_start(32'h020);
    load_beat(0, 31, 1, 2, 0, 32'h20 + 1 + 40000, 0, 0);
    run_beats(1, 1'b1, 100, 1'b0);
    drain(3, 1'b0);
    check("brel far n_writes", 64'(wr_data_q.size()), 64'd0);
    check("brel far illegal", 64'(bus.err_illegal), 64'd1);
`endif

    // Randomized sessions
    for (int s = 0; s < 40; s++) begin
      int nb;
      nb = int'($urandom_range(1, 6));
      for (int k = 0; k < nb; k++)
        load_beat(k, ($urandom_range(9) == 0) ? $urandom_range(39, 63) : $urandom_range(0, 38),
                  $urandom_range(31), $urandom_range(31), $urandom_range(31), $urandom_range(31),
                  $urandom_range(16'hffff), $urandom_range(26'h3ffffff));
      do_start($urandom_range(AMOD - 1));
      run_beats(nb, 1'b1, 70, 1'b1);
      drain(3, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_inst_encoder.md
# mips_inst_encoder

Sequential instruction encoder and instruction-memory loader for the single-cycle MIPS core: the inverse of the control decoder. It accepts symbolic instructions (mnemonic ID plus operand fields) over a valid/ready stream and encodes each into a 32-bit MIPS-I word. It then writes the words to consecutive instruction-memory addresses through the IM write port. Test benches and the boot path use it to load programs without hand-assembled hex.

## Interface
Parameters:
- `ADDR_W`, 10: IM word-address width.
- `MAX_WORDS`, 1024: maximum words written per load session.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  clock; all logic on the rising edge.
- `rst`  input  1  synchronous active-high reset.
- `start`  input  1  one-cycle pulse; begins a load session at `base_addr`.
- `base_addr`  input  ADDR_W  first IM word address, sampled on `start`.
- `in_valid`  input  1  instruction beat valid.
- `in_ready`  output  1  encoder can accept a beat.
- `in_last`  input  1  marks the final beat of the session.
- `mnem`  input  6  mnemonic ID (see Operation).
- `rs`, `rt`, `rd`, `shamt`  input  5 each  register and shift fields.
- `imm`  input  16  immediate or branch operand.
- `target`  input  26  jump target field.
- `im_we`  output  1  IM write strobe.
- `im_addr`  output  ADDR_W  IM word address.
- `im_wdata`  output  32  encoded instruction.
- `busy`  output  1  high in LOAD or DONE.
- `done`  output  1  one-cycle pulse at session end.
- `word_cnt`  output  ADDR_W+1  words written this session.
- `err_illegal`  output  1  sticky; set by an unknown `mnem`.
- `err_overflow`  output  1  sticky; set when the `MAX_WORDS` limit is hit before `in_last`.

## Operation
- Mnemonic IDs:
  - 0–15: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav.
  - 16: jr. 17: jalr.
  - 18–25: addi, addiu, slti, sltiu, andi, ori, xori, lui.
  - 26–30: lw, sw, lb, lbu, sb.
  - 31–36: beq, bne, bgez, bltz, bgtz, blez.
  - 37: j. 38: jal.
  - 39–63: illegal.
- R-type word = {6'b000000, rs, rt, rd, shamt, funct}, standard MIPS-I funct values.
  - sll, srl, sra force rs=0.
  - The other R-types force shamt=0.
  - jr forces rt=rd=0. jalr forces rt=0.
- I-type word = {opcode, rs, rt, imm}.
  - lui forces rs=0.
  - bgez: opcode 000001, rt=00001. bltz: opcode 000001, rt=00000.
  - bgtz, blez force rt=0.
- J-type word = {opcode, target}.
- FSM states:
  - IDLE:
    - `in_ready`=0.
    - On `start`: latch `base_addr` into the address pointer, clear `word_cnt`, `err_illegal` and `err_overflow`, and go to LOAD.
  - LOAD:
    - `in_ready` = (`word_cnt` < `MAX_WORDS`).
    - Accept: `in_valid`&`in_ready`.
      - Legal beat: register the encoded word. Next cycle `im_we`=1 at the current pointer; pointer and `word_cnt` increment.
      - Illegal beat: consumed, no write, `err_illegal` set, pointer unchanged.
    - Accepted beat with `in_last` → DONE.
    - `word_cnt` reaches `MAX_WORDS` without `in_last` → set `err_overflow` and go to DONE.
  - DONE:
    - `done`=1 for one cycle; → IDLE.
- `start` outside IDLE is ignored.
- Pointer arithmetic is modulo 2^ADDR_W; wrap-around is permitted and not flagged.

## Timing
- Reset values: `in_ready`=0, `im_we`=0, `im_addr`=0, `im_wdata`=0, `busy`=0, `done`=0, `word_cnt`=0, both error flags 0. FSM is in IDLE.
- Latency: a beat accepted at edge N produces `im_we`/`im_addr`/`im_wdata` valid for the cycle after edge N; `im_we` is high for exactly one cycle per legal beat.
- Throughput: one beat per cycle in LOAD; back-to-back writes go to consecutive addresses.
- `done` asserts the cycle after the final write strobe, i.e. two cycles after the last accept edge.
- `in_ready` falls in the same cycle that `word_cnt` reaches `MAX_WORDS`; no beat is ever accepted beyond the limit.
- `rst` asserted mid-session:
  - Any pending write is dropped (`im_we`=0 in the next cycle).
  - All state returns to reset values; no `done` pulse is issued.

## Configuration
- Macro: `ENCODER_BRANCH_REL_EN`.
- Defined:
  - For mnem 31–36, `imm` is an absolute IM word address.
  - The encoder emits offset = `imm` − (write address + 1), truncated to 16 bits.
  - If the true signed offset lies outside [−32768, 32767], the beat is treated as illegal: no write and `err_illegal` set.
- Undefined: `imm` is copied verbatim into the branch offset field.

## Test plan
- Reset, then `start` with `base_addr`=0x010, then beats addu(rs=1, rt=2, rd=3) and ori(rs=0, rt=4, imm=0x00FF, `in_last`):
  - writes 0x00221821 @0x010 and 0x340400FF @0x011;
  - `done` pulse; `word_cnt`=2.
- Single-beat sessions for sll(rt=5, rd=6, shamt=4, rs=7), bgez(rs=8, imm=0xFFFE), jal(target=0x0100000):
  - sll → 0x00053100;
  - bgez → 0x0501FFFE (undefined macro);
  - jal → 0x0C100000.
- mnem=50 mid-stream between two legal beats:
  - exactly two writes, at consecutive addresses;
  - `err_illegal`=1 until the next `start`.
- `MAX_WORDS`=4 with 6 beats offered and no `in_last`:
  - 4 writes;
  - `in_ready` low after the 4th accept;
  - `err_overflow`=1; `done` pulses.
- `in_valid` toggled randomly with `rst` pulsed after the 2nd accept:
  - no further `im_we`;
  - outputs at reset values; FSM idle.
- Macro defined, branch at address 0x020 with `imm`=0x010:
  - offset field = 0xFFEF;
  - an `imm` 40000 words away sets `err_illegal` with no write.
